iir_lowpass_pow2k_filter: RTL and testbench

Cascaded first-order IIR low-pass filter whose coefficient is a power of two, so each stage needs only a shift and an add, with no multipliers. It smooths a slowly varying measurement word, such as the period or frequency value from the theremin sensor PLL, before downstream scaling. One update happens per clock-enabled cycle. Unsigned or two's-complement data is selected by parameter.

---
 rtl/iir_lowpass_pow2k_filter_pkg.sv | 14 +
 rtl/iir_lowpass_pow2k_stage.sv | 46 ++++
 rtl/iir_lowpass_pow2k_filter.sv | 65 ++++++
 tb/tb_iir_lowpass_pow2k_filter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iir_lowpass_pow2k_filter_pkg.sv
// Shared constants and helpers for the power-of-two IIR low-pass filter.
//   MaxShiftBits / MaxStages : legal upper bounds for the coefficient shift and stage count
//   acc_width()              : accumulator width for a given input width and shift
package iir_lowpass_pow2k_filter_pkg;

  localparam int unsigned MaxShiftBits = 16;
  localparam int unsigned MaxStages    = 4;

  // Integer bits + fractional bits + one guard/sign bit.
  function automatic int unsigned acc_width(int unsigned in_bits, int unsigned shift_bits);
    return in_bits + shift_bits + 1;
  endfunction

endpackage

// File: rtl/iir_lowpass_pow2k_stage.sv
// One first-order low-pass stage: acc <= acc + ((x - acc) >>> ShiftBits).
// The input x is already at the accumulator's fixed-point scale (ShiftBits fractional bits).
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset, clears the accumulator
//   ce    in  clock enable, the accumulator only moves when high
//   x     in  stage input, AccBits wide, full precision
//   acc   out registered accumulator, AccBits wide, full precision
module iir_lowpass_pow2k_stage #(
  parameter int unsigned AccBits   = 36,
  parameter int unsigned ShiftBits = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [AccBits-1:0] x,
  output logic [AccBits-1:0] acc
);

  logic        [AccBits-1:0] acc_q;
  logic        [AccBits-1:0] acc_d;
  logic signed [AccBits-1:0] diff;
  logic signed [AccBits-1:0] delta;

  always_comb begin
    // The guard bit keeps x - acc exact; both operands are always in range.
    diff  = $signed(x) - $signed(acc_q);
    // Arithmetic shift: floor division, so settling from below stalls just short of x.
    delta = diff >>> ShiftBits;
    acc_d = acc_q;
    if (ce) begin
      acc_d = acc_q + $unsigned(delta);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/iir_lowpass_pow2k_filter.sv
// Cascaded first-order IIR low-pass filter with a 2^-K coefficient (shift-and-add only).
// Ports:
//   CLK       in  clock, all state updates on its rising edge
//   RESET     in  asynchronous active-low reset
//   CE        in  clock enable, state advances only on enabled edges
//   IN_VALUE  in  INPUT_BITS input sample (unsigned or two's complement per SIGNED_DATA)
//   OUT_VALUE out RESULT_BITS filtered output, taken directly from the last accumulator
module iir_lowpass_pow2k_filter
  import iir_lowpass_pow2k_filter_pkg::*;
#(
  parameter int unsigned INPUT_BITS        = 30,
  parameter int unsigned RESULT_BITS       = 30,
  parameter int unsigned FILTER_SHIFT_BITS = 5,
  parameter int unsigned FILTER_STAGES     = 2,
  parameter int unsigned SIGNED_DATA       = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CE,
  input  logic [INPUT_BITS-1:0]  IN_VALUE,
  output logic [RESULT_BITS-1:0] OUT_VALUE
);

  localparam int unsigned K       = FILTER_SHIFT_BITS;
  localparam int unsigned A       = acc_width(INPUT_BITS, FILTER_SHIFT_BITS);
  localparam int unsigned ExtBits = A - 1 + RESULT_BITS;

  if (K < 1 || K > MaxShiftBits || FILTER_STAGES < 1 || FILTER_STAGES > MaxStages)
  begin : gen_param_check
    $error("iir_lowpass_pow2k_filter: FILTER_SHIFT_BITS or FILTER_STAGES out of range");
  end

  logic         sign_fill;
  logic [A-1:0] x_wide;
  // chain[0] is the scaled input, chain[i+1] is the accumulator of stage i.
  logic [A-1:0] chain [FILTER_STAGES+1];

  assign sign_fill = (SIGNED_DATA != 0) ? IN_VALUE[INPUT_BITS-1] : 1'b0;
  assign x_wide    = {{(A - INPUT_BITS){sign_fill}}, IN_VALUE};
  assign chain[0]  = x_wide << K;

  for (genvar i = 0; i < FILTER_STAGES; i++) begin : gen_stage
    iir_lowpass_pow2k_stage #(
      .AccBits  (A),
      .ShiftBits(K)
    ) u_stage (
      .clk  (CLK),
      .rst_n(RESET),
      .ce   (CE),
      .x    (chain[i]),
      .acc  (chain[i+1])
    );
  end

  // Integer and fractional bits of the last accumulator followed by zero padding; the top
  // RESULT_BITS of this covers truncation, pass-through and fraction-extension alike.
  logic [ExtBits-1:0] ext;
  logic               unused_bits;

  assign ext         = {chain[FILTER_STAGES][A-2:0], {RESULT_BITS{1'b0}}};
  assign OUT_VALUE   = ext[ExtBits-1 -: RESULT_BITS];
  // The guard bit and dropped low bits never reach the output.
  assign unused_bits = ^{chain[FILTER_STAGES][A-1], ext};

endmodule

// File: tb/tb_iir_lowpass_pow2k_filter.sv
// Self-checking bench for iir_lowpass_pow2k_filter: five configurations run side by side and
// every cycle is compared to an arithmetic model; directed phases pin the model with literals.
module tb_iir_lowpass_pow2k_filter;

  localparam longint Scale        = 32;           // 2^K for K = 5
  localparam int     SettleBudget = 20 * 32 * 2;  // 20 * 2^K * stages enabled cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0;
  logic [29:0] in_u = '0;
  logic [29:0] in_s = '0;
  logic [29:0] in_k = '0;
  logic [29:0] out_u0;
  logic [29:0] out_s;
  logic [29:0] out_k;
  logic [33:0] out_w;
  logic [23:0] out_n;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  // Model accumulators, in units of 2^-K of an input LSB.
  longint m_u[2];
  longint m_s[2];
  longint m_k;

  iir_lowpass_pow2k_filter #(
    .INPUT_BITS(30), .RESULT_BITS(30), .FILTER_SHIFT_BITS(5), .FILTER_STAGES(2), .SIGNED_DATA(0)
  ) u_dut_u (
    .CLK(clk), .RESET(rst_n), .CE(ce), .IN_VALUE(in_u), .OUT_VALUE(out_u0)
  );

  iir_lowpass_pow2k_filter #(
    .INPUT_BITS(30), .RESULT_BITS(30), .FILTER_SHIFT_BITS(5), .FILTER_STAGES(2), .SIGNED_DATA(1)
  ) u_dut_s (
    .CLK(clk), .RESET(rst_n), .CE(ce), .IN_VALUE(in_s), .OUT_VALUE(out_s)
  );

  iir_lowpass_pow2k_filter #(
    .INPUT_BITS(30), .RESULT_BITS(30), .FILTER_SHIFT_BITS(1), .FILTER_STAGES(1), .SIGNED_DATA(0)
  ) u_dut_k (
    .CLK(clk), .RESET(rst_n), .CE(ce), .IN_VALUE(in_k), .OUT_VALUE(out_k)
  );

  iir_lowpass_pow2k_filter #(
    .INPUT_BITS(30), .RESULT_BITS(34), .FILTER_SHIFT_BITS(5), .FILTER_STAGES(2), .SIGNED_DATA(0)
  ) u_dut_w (
    .CLK(clk), .RESET(rst_n), .CE(ce), .IN_VALUE(in_u), .OUT_VALUE(out_w)
  );

  iir_lowpass_pow2k_filter #(
    .INPUT_BITS(30), .RESULT_BITS(24), .FILTER_SHIFT_BITS(5), .FILTER_STAGES(2), .SIGNED_DATA(0)
  ) u_dut_n (
    .CLK(clk), .RESET(rst_n), .CE(ce), .IN_VALUE(in_u), .OUT_VALUE(out_n)
  );

  always #5 clk = ~clk;

  // Floor division for a positive divisor.
  function automatic longint fdiv(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // acc moves by floor(1/2^k of the remaining distance to the target).
  function automatic longint stage_step(longint acc, longint target, int k);
    return acc + fdiv(target - acc, longint'(1) << k);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_u[0] <= 0; m_u[1] <= 0;
      m_s[0] <= 0; m_s[1] <= 0;
      m_k    <= 0;
    end else if (ce) begin
      m_u[0] <= stage_step(m_u[0], longint'(in_u) * Scale, 5);
      m_u[1] <= stage_step(m_u[1], m_u[0], 5);
      m_s[0] <= stage_step(m_s[0], longint'($signed(in_s)) * Scale, 5);
      m_s[1] <= stage_step(m_s[1], m_s[0], 5);
      m_k    <= stage_step(m_k, longint'(in_k) * 2, 1);
    end
  end

  task automatic chk_true(string name, bit ok, longint act, longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk(string name, longint act, longint req);
    chk_true(name, act == req, act, req);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_u", longint'(out_u0), fdiv(m_u[1], Scale));
      chk("model_s", longint'($signed(out_s)), fdiv(m_s[1], Scale));
      chk("model_k", longint'(out_k), fdiv(m_k, 2));
      chk("model_wide", longint'(out_w), fdiv(m_u[1], 2));
      chk("model_narrow", longint'(out_n), fdiv(fdiv(m_u[1], Scale), 64));
    end
  end

  // Reset is moved away from the falling edge so the compare process never races it.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_u", longint'(out_u0), 0);
    chk("reset_async_s", longint'($signed(out_s)), 0);
    repeat (2) @(negedge clk);
    chk("reset_hold_u", longint'(out_u0), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Watches the unsigned default instance: monotonic in one direction, never past the target
  // window, and inside [lo, hi] within the budget and at the end.
  task automatic settle(string name, longint lo, longint hi, bit rising);
    longint prev;
    longint cur;
    int     first;
    first = -1;
    prev  = longint'(out_u0);
    cur   = prev;
    for (int c = 1; c <= SettleBudget; c++) begin
      @(negedge clk);
      cur = longint'(out_u0);
      if (rising) chk_true({name, "_monotonic"}, cur >= prev && cur <= hi, cur, prev);
      else        chk_true({name, "_monotonic"}, cur <= prev && cur >= lo, cur, prev);
      if (first < 0 && cur >= lo && cur <= hi) first = c;
      prev = cur;
    end
    chk_true({name, "_settled"}, first >= 0 && cur >= lo && cur <= hi, cur, lo);
  endtask

  initial begin
    int n1;
    int n4;
    longint prev;

    // Reset dominates a live input with CE high; then hold with CE low.
    in_u = 30'd100_000_000;
    ce   = 1'b1;
    do_reset();
    ce       = 1'b0;
    check_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("hold_ce0", longint'(out_u0), 0);

    // Step up. A single K=1 stage moves halfway in one edge: 0 -> 1000 gives 500.
    in_s = 30'd100_000_000;
    in_k = 30'd1000;
    ce   = 1'b1;
    @(negedge clk);
    chk("k1_first_edge", longint'(out_k), 500);
    // Floor bias can leave each of the two stages up to one LSB short from below.
    settle("step_up", 100_000_000 - 2, 100_000_000, 1'b1);
    chk_true("signed_up", $signed(out_s) >= 99_999_998 && $signed(out_s) <= 100_000_000,
             longint'($signed(out_s)), 100_000_000);

    // From above the floor keeps stepping until the result is exact.
    in_u = 30'd50_000_000;
    in_s = 30'(-100_000_000);
    settle("step_down", 50_000_000, 50_000_000, 1'b0);
    chk("signed_neg100m", longint'($signed(out_s)), -100_000_000);

    // -1,000,000 in unsigned mode is just a large positive value.
    in_u = 30'(-1_000_000);
    in_s = 30'(-200_000_000);
    settle("unsigned_wrap", 1_072_741_822, 1_072_741_824, 1'b1);
    chk("signed_neg200m", longint'($signed(out_s)), -200_000_000);

    in_u = 30'd200_000_000;
    settle("unwrap_down", 200_000_000, 200_000_000, 1'b0);

    // CE gating: enabling one edge in four stretches the response exactly 4x.
    ce = 1'b0;
    do_reset();
    in_u = 30'd100_000_000;
    @(negedge clk);
    ce = 1'b1;
    n1 = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (n1 < 0 && out_u0 >= 30'd50_000_000) n1 = c;
    end
    chk_true("ce_full_rate_reached", n1 > 0, n1, 1);
    ce = 1'b0;
    do_reset();
    @(negedge clk);
    n4 = -1;
    for (int c = 1; c <= 1600; c++) begin
      ce   = (c % 4 == 0);
      prev = longint'(out_u0);
      @(negedge clk);
      if (!ce) chk("ce_frozen", longint'(out_u0), prev);
      if (n4 < 0 && out_u0 >= 30'd50_000_000) n4 = c;
    end
    chk("ce_stretch_4x", n4, 4 * n1);

    // Random inputs and enables, with one asynchronous reset mid-stream.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      ce = ($urandom_range(3) != 0);
      if ($urandom_range(31) == 0) begin
        in_u = 30'($urandom);
        in_s = 30'($urandom);
        in_k = 30'($urandom);
      end
      if (c == 700) do_reset();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
